load_store_unit: RTL and testbench
==================================

# load_store_unit

Sub-word load/store sequencer between the execute stage and the 128-byte big-endian, word-ported data memory. It accepts one memory request at a time from the core and returns sign/zero-extended load data. Word stores are issued directly; byte and halfword stores use a read-modify-write sequence. Misaligned, out-of-range and illegal requests are rejected without any memory access.

## Interface

- ADDR_W, 7: implemented byte-address width (memory size 2^ADDR_W bytes).
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; core holds it and its fields stable until accepted.
- req_ready  output  1  high only in IDLE with rst low; a request is accepted on a posedge where req_valid && req_ready.
- req_store  input  1  1 = store, 0 = load.
- req_op  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (funct3 encoding).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle pulse marking request completion.
- rsp_data  output  32  load result; 0 for stores and errors; registered, holds until next response.
- rsp_err  output  1  valid with rsp_valid: misaligned, out of range or illegal op.
- mem_addr  output  32  word-aligned address {addr[31:2], 2'b00}.
- mem_read  output  1  combinational read enable; mem_rdata valid in the same cycle.
- mem_write  output  1  write enable, sampled by memory at posedge.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  word read from memory, bits [31:24] = byte at offset 0.

## Operation

- FSM states: IDLE, READ, WRITE, RESP. Reset state IDLE.
- Accept in IDLE: latch op, store flag, address, wdata. Decode error = any of: illegal op (011, 110, 111, or store with 100/101); H/HU with addr[0]=1; W with addr[1:0]!=0; any addr bit at or above ADDR_W set.
- Error: IDLE -> RESP, rsp_err=1, rsp_data=0, no mem_read/mem_write at any point.
- Load: IDLE -> READ (mem_read=1, capture extracted result at end of cycle) -> RESP.
- SW: IDLE -> WRITE (mem_write=1, mem_wdata=wdata) -> RESP.
- SB/SH: IDLE -> READ (capture mem_rdata with the new bytes merged in) -> WRITE (merged word) -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Byte lane, big-endian: offset o = addr[1:0] selects bits [31-8o -: 8]. Halfword offset 0 selects [31:16]; offset 2 selects [15:0].
- Extension: B/H sign-extend; BU/HU zero-extend; W passes through.
- Merge: only the addressed byte/half lanes are replaced; the other lanes keep the value read.
- mem_read/mem_write decode from state and are gated by !rst. Both are 0 in IDLE and RESP.
- mem_addr is driven from the latched address in READ/WRITE and is 0 otherwise.

## Timing

- Accept edge = E0. Error: rsp_valid in cycle E0..E0+1. Load and SW: rsp_valid in E1..E2. SB/SH: rsp_valid in E2..E3.
- req_ready returns high the cycle after RESP; maximum throughput is one request per 2/3/4 cycles (err/load-SW/sub-word).
- A write issued at edge Ek is visible to a read in any later request, because the earliest following READ is at least 2 cycles later.
- Reset values: state IDLE, req_ready 0 while rst is high, rsp_valid 0, rsp_err 0, rsp_data 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0.
- rst mid-operation: at the rst edge go to IDLE and drop the in-flight request without a response. A WRITE cycle coinciding with rst issues no write, so memory is unchanged.
- req_valid while not ready: ignored, never queued.

## Test plan

- Memory word at 0x10 = 0x80F01234. LW 0x10 -> 0x80F01234. LB 0x10 -> 0xFFFFFF80. LBU 0x10 -> 0x00000080. LH 0x10 -> 0xFFFF80F0. LHU 0x12 -> 0x00001234. Each load has rsp_valid exactly 2 cycles after accept.
- SW 0x12345678 @0x20, then LW 0x20 -> 0x12345678. SW: one mem_write cycle, response 2 cycles after accept.
- Word at 0x20 = 0x11223344. SB 0xAB @0x22 -> memory becomes 0x1122AB44. SH 0xBEEF @0x20 -> memory becomes 0xBEEFAB44. Each shows one mem_read cycle, then one mem_write cycle, with rsp_valid 3 cycles after accept.
- SH @0x21, LW @0x22, LB @0x80, store with op 100 -> each gives rsp_err=1 and rsp_data=0 one cycle after accept; mem_read and mem_write stay 0 throughout.
- SB @0x30 with rst pulsed during the WRITE cycle -> mem_write=0, word at 0x30 unchanged, no rsp_valid; req_ready=1 the cycle after rst drops.
- req_valid held high for 6 cycles with one LW @0x10 -> exactly one acceptance and one rsp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: sub-word load/store sequencer for a word-ported, big-endian
// data memory. One request in flight; byte/half stores use read-modify-write.
module load_store_unit #(
   parameter int unsigned ADDR_W = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state;
   logic        store_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] wbuf;

   logic        dec_err;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_res;
   logic [31:0] merged;

   assign req_ready = (state == IDLE) && !rst;
   assign mem_read  = (state == READ) && !rst;
   assign mem_write = (state == WRITE) && !rst;
   assign mem_addr  = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
   assign mem_wdata = wbuf;

   // Request decode: illegal op, misalignment and out-of-range address
   always_comb begin
      dec_err = 1'b0;
      case (req_op)
         3'b000:  dec_err = 1'b0;
         3'b001:  dec_err = req_addr[0];
         3'b010:  dec_err = (req_addr[1:0] != 2'b00);
         3'b100:  dec_err = req_store;
         3'b101:  dec_err = req_store || req_addr[0];
         default: dec_err = 1'b1;
      endcase
      if (|req_addr[31:ADDR_W])
         dec_err = 1'b1;
   end

   // Big-endian lane extraction with extension, and store-data merge
   always_comb begin
      // byte at offset o sits (3-o) bytes up from bit 0
      byte_sh  = {~addr_q[1:0], 3'b000};
      half_sh  = addr_q[1] ? 5'd0 : 5'd16;
      rd_byte  = 8'(mem_rdata >> byte_sh);
      rd_half  = 16'(mem_rdata >> half_sh);
      load_res = mem_rdata;
      merged   = wdata_q;
      case (op_q[1:0])
         2'b00: begin
            load_res = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            merged   = (mem_rdata & ~(32'h0000_00FF << byte_sh)) |
                       ({24'h0, wdata_q[7:0]} << byte_sh);
         end
         2'b01: begin
            load_res = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            merged   = (mem_rdata & ~(32'h0000_FFFF << half_sh)) |
                       ({16'h0, wdata_q[15:0]} << half_sh);
         end
         default: begin
            load_res = mem_rdata;
            merged   = wdata_q;
         end
      endcase
   end

   // Sequencer FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         store_q   <= 1'b0;
         op_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wbuf      <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q <= req_store;
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (dec_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     state     <= RESP;
                  end else if (req_store && req_op == 3'b010) begin
                     wbuf  <= req_wdata;
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (store_q) begin
                  wbuf  <= merged;
                  state <= WRITE;
               end else begin
                  rsp_data  <= load_res;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            WRITE: begin
               rsp_data  <= '0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, per-cycle scoreboard,
// and a word memory attached to the DUT memory port.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(7)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Data memory seen by the DUT (preloaded through a bench-only port)
   logic [31:0] dmem [0:31];
   logic        pre_we = 1'b0;
   logic [4:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;
   assign mem_rdata = mem_read ? dmem[mem_addr[6:2]] : 32'hDEAD_BEEF;
   always @(posedge clk) begin
      if (mem_write) dmem[mem_addr[6:2]] <= mem_wdata;
      else if (pre_we) dmem[pre_idx] <= pre_data;
   end

   // Reference model state: byte-addressed, byte 0 is the most significant
   logic [7:0] ref_b [0:127];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accepts = 0;
   int issued = 0;
   bit mon_en = 1'b0;

   bit          exp_rd [int];
   bit          exp_wr [int];
   logic [31:0] exp_ad [int];
   logic [31:0] exp_wd [int];
   logic [32:0] exp_rsp [int];

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (req_valid && req_ready) accepts++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every cycle, compare memory port and response against schedule
   bit          m_er, m_ew, m_rv;
   logic [32:0] m_r;
   always @(negedge clk) begin
      if (mon_en) begin
         m_er = exp_rd.exists(cyc) != 0;
         m_ew = exp_wr.exists(cyc) != 0;
         m_rv = exp_rsp.exists(cyc) != 0;
         chk("mem_read", 32'(mem_read), 32'(m_er));
         chk("mem_write", 32'(mem_write), 32'(m_ew));
         if (m_ew) chk("mem_wdata", mem_wdata, exp_wd[cyc]);
         chk("mem_addr", mem_addr, (exp_ad.exists(cyc) != 0) ? exp_ad[cyc] : 32'h0);
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
         if (m_rv && rsp_valid) begin
            m_r = exp_rsp[cyc];
            chk("rsp_data", rsp_data, m_r[31:0]);
            chk("rsp_err", 32'(rsp_err), 32'(m_r[32]));
         end
         if (rst) chk("ready_in_rst", 32'(req_ready), 32'h0);
      end
   end

   // Reference model: outcome of one request from the architectural rules
   task automatic model_req(input logic st, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input bit apply,
                            output bit err, output logic [31:0] data,
                            output logic [31:0] nw, output int lat);
      int size;
      logic [31:0] v;
      int base;
      err = 1'b0; data = '0; nw = '0; lat = 0;
      case (op)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (size == 0) err = 1'b1;
      else if (st && op >= 3'd4) err = 1'b1;
      else if (a >= 32'd128) err = 1'b1;
      else if ((a % size) != 0) err = 1'b1;
      if (err) return;
      if (!st) begin
         v = '0;
         for (int i = 0; i < size; i++) v = (v << 8) | 32'(ref_b[a + i]);
         if (op < 3'd4 && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 1);
         data = v;
         lat = 1;
      end else begin
         if (apply)
            for (int i = 0; i < size; i++) ref_b[a + i] = 8'(wd >> (8*(size-1-i)));
         base = int'(a) & ~3;
         nw = {ref_b[base], ref_b[base+1], ref_b[base+2], ref_b[base+3]};
         lat = (size == 4) ? 1 : 2;
      end
   endtask

   // Present one request, schedule its expected effects, optionally wait it out
   task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit has_lit, input logic [31:0] lit,
                        input bit rst_mode, input bit wait_done);
      int n;
      int ac;
      int wc;
      bit err;
      logic [31:0] data, nw;
      int lat;
      req_store = st; req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'h0, 32'h1);
         req_valid = 1'b0;
         return;
      end
      ac = cyc + 1;
      model_req(st, op, a, wd, !rst_mode, err, data, nw, lat);
      if (has_lit) chk("model_literal", data, lit);
      if (!err) begin
         if (!(st && op == 3'b010)) begin
            exp_rd[ac] = 1'b1;
            exp_ad[ac] = a & ~32'h3;
         end
         if (st) begin
            wc = ac + ((op == 3'b010) ? 0 : 1);
            exp_ad[wc] = a & ~32'h3;
            if (!rst_mode) begin
               exp_wr[wc] = 1'b1;
               exp_wd[wc] = nw;
            end
         end
      end
      if (!rst_mode) exp_rsp[ac + lat] = {err, data};
      issued++;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (rst_mode) begin
         @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk("ready_after_rst", 32'(req_ready), 32'h1);
      end else if (wait_done) begin
         while (cyc < ac + lat + 1) @(negedge clk);
      end
   endtask

   int acc0;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_op = '0;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         pre_we = 1'b1;
         pre_idx = 5'(i);
         pre_data = (i == 4) ? 32'h80F0_1234 : (i == 12) ? 32'hCAFE_F00D : 32'h0101_0101 * i;
         for (int k = 0; k < 4; k++) ref_b[4*i + k] = 8'(pre_data >> (24 - 8*k));
      end
      @(negedge clk);
      pre_we = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_mem_read", 32'(mem_read), 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'h1);

      // loads from 0x80F01234
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h80F0_1234, 1'b0, 1'b1);
      issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
      issue(1'b0, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
      issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b1, 32'hFFFF_80F0, 1'b0, 1'b1);
      issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
      issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b1);

      // word store then readback
      issue(1'b1, 3'b010, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);

      // read-modify-write stores
      issue(1'b1, 3'b010, 32'h20, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 3'b000, 32'h22, 32'hFFFF_FFAB, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("mem_after_sb", dmem[8], 32'h1122_AB44);
      issue(1'b1, 3'b001, 32'h20, 32'h1234_BEEF, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("mem_after_sh", dmem[8], 32'hBEEF_AB44);
      issue(1'b0, 3'b001, 32'h22, 32'h0, 1'b1, 32'hFFFF_AB44, 1'b0, 1'b1);
      issue(1'b0, 3'b100, 32'h23, 32'h0, 1'b1, 32'h0000_0044, 1'b0, 1'b1);

      // rejected requests
      issue(1'b1, 3'b001, 32'h21, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h22, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b000, 32'h80, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 3'b100, 32'h10, 32'h55, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
      chk("mem_after_errs", dmem[4], 32'h80F0_1234);

      // reset during the write cycle of a byte store
      issue(1'b1, 3'b000, 32'h31, 32'h5A, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("mem_after_rst", dmem[12], 32'hCAFE_F00D);

      // request held valid while busy is accepted once
      acc0 = accepts;
      issue(1'b1, 3'b000, 32'h31, 32'h77, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("busy_not_ready", 32'(req_ready), 32'h0);
      issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, 32'hCA77_F00D, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("held_accepts", 32'(accepts - acc0), 32'd2);
      chk("total_accepts", 32'(accepts), 32'(issued));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
